// File: rtl/mmio_io_hub_pkg.sv
// Shared definitions for the MMIO I/O hub: register offsets, bit positions
// inside the STATUS / HEX_CTRL / CTRL words, and FIFO sizing helpers.
package mmio_io_hub_pkg;

  // Word offsets decoded from addr[2:0]
  typedef enum logic [2:0] {
    REG_STATUS   = 3'd0,
    REG_KEYDATA  = 3'd1,
    REG_LEDS     = 3'd2,
    REG_HEX      = 3'd3,
    REG_HEX_CTRL = 3'd4,
    REG_CTRL     = 3'd5,
    REG_RSVD6    = 3'd6,
    REG_RSVD7    = 3'd7
  } reg_addr_e;

  // STATUS bit positions
  localparam int STAT_NOT_EMPTY = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVF       = 2;
  localparam int STAT_COUNT_LSB = 8;

  // HEX_CTRL field positions
  localparam int HC_BLANK_LSB = 0;
  localparam int HC_BLINK_LSB = 8;
  localparam int HC_LZ_BIT    = 16;
  localparam int HC_MASK_W    = 8;

  // CTRL strobe bits
  localparam int CTRL_CLR_OVF = 0;
  localparam int CTRL_FLUSH   = 1;

  // Ceiling log2; clog2(1) = 0
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Occupancy counter must hold the value DEPTH itself
  function automatic int count_width(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mmio_io_hub_sync_fifo.sv
// Single-clock FIFO with flush. Push into a full FIFO is accepted only when a
// pop happens in the same cycle; flush overrides both push and pop.
module sync_fifo
  import mmio_io_hub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic                          flush,
  input  logic [WIDTH-1:0]              wdata,
  output logic [WIDTH-1:0]              rdata,
  output logic                          full,
  output logic                          empty,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = count_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointer and occupancy tracking; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PTR_W'(do_push);
      rd_ptr_q <= rd_ptr_q + PTR_W'(do_pop);
      count_q  <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage write port
  always_ff @(posedge clock) begin
    // NOTE: storage is not reset; stale entries are never visible because the pointers and count are.
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/mmio_io_hub.sv
// Memory-mapped hub between the processor data bus and the keyboard, LED and
// seven-segment peripherals: key FIFO, LED/hex registers, blink and blanking.
module mmio_io_hub
  import mmio_io_hub_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 12,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       addr,
  input  logic                    we,
  input  logic                    re,
  input  logic [31:0]             wdata,
  output logic [31:0]             rdata,
  output logic                    rvalid,
  input  logic                    ps2_key_pressed,
  input  logic [7:0]              ps2_out,
  output logic [7:0]              leds,
  output logic [4*NUM_DIGITS-1:0] hex_nibbles,
  output logic [NUM_DIGITS-1:0]   hex_blank,
  output logic                    key_irq
);

  localparam int CNT_W   = count_width(FIFO_DEPTH);
  localparam int HEX_W   = 4 * NUM_DIGITS;
  localparam int BLINK_W = (clog2(BLINK_DIV) > 0) ? clog2(BLINK_DIV) : 1;

  reg_addr_e            reg_sel;
  logic                 ps2_prev_q;
  logic                 push_edge;
  logic                 fifo_pop;
  logic                 fifo_flush;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [7:0]           fifo_head;
  logic [CNT_W-1:0]     fifo_count;
  logic                 clr_ovf;
  logic                 ovf_set;
  logic                 ovf_q, ovf_d;
  logic [7:0]           leds_q;
  logic [HEX_W-1:0]     hex_q;
  logic [HC_MASK_W-1:0] blank_mask_q;
  logic [HC_MASK_W-1:0] blink_mask_q;
  logic                 lz_en_q;
  logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic                 phase_q, phase_d;
  logic [NUM_DIGITS-1:0] lz;
  logic                 zero_run;
  logic [31:0]          rd_word;
  logic [31:0]          rdata_q;
  logic                 rvalid_q;
  logic                 unused_bits;

  assign reg_sel    = reg_addr_e'(addr[2:0]);
  assign push_edge  = ps2_key_pressed & ~ps2_prev_q;
  assign fifo_pop   = re & (reg_sel == REG_KEYDATA) & ~fifo_empty;
  assign fifo_flush = we & (reg_sel == REG_CTRL) & wdata[CTRL_FLUSH];
  assign clr_ovf    = we & (reg_sel == REG_CTRL) & wdata[CTRL_CLR_OVF];
  // A flushed byte is discarded on purpose, so it does not count as an overflow
  assign ovf_set    = push_edge & fifo_full & ~fifo_pop & ~fifo_flush;
  // Upper address bits and wide write-data bits are intentionally ignored
  assign unused_bits = ^{addr, wdata};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_key_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_edge),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .wdata (ps2_out),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Bus-writable registers and PS2 level history for edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ps2_prev_q   <= 1'b0;
      leds_q       <= '0;
      hex_q        <= '0;
      blank_mask_q <= '0;
      blink_mask_q <= '0;
      lz_en_q      <= 1'b0;
    end else begin
      ps2_prev_q <= ps2_key_pressed;
      if (we) begin
        case (reg_sel)
          REG_LEDS: leds_q <= wdata[7:0];
          REG_HEX:  hex_q  <= wdata[HEX_W-1:0];
          REG_HEX_CTRL: begin
            blank_mask_q <= wdata[HC_BLANK_LSB +: HC_MASK_W];
            blink_mask_q <= wdata[HC_BLINK_LSB +: HC_MASK_W];
            lz_en_q      <= wdata[HC_LZ_BIT];
          end
          default: ;
        endcase
      end
    end
  end

  // Sticky overflow: a new overflow event wins over a same-cycle clear
  always_comb begin
    // NOTE: defaults are assigned first so every path drives every output and no latch is inferred.
    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;
  end

  // Blink divider: phase flips each time the counter wraps at BLINK_DIV-1
  always_comb begin
    blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    phase_d     = phase_q;
    if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  // Overflow flag and blink state registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ovf_q       <= 1'b0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      ovf_q       <= ovf_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  // Leading-zero suppression: scan from the top digit down while digits stay zero
  always_comb begin
    lz       = '0;
    zero_run = lz_en_q;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run & (hex_q[4*i +: 4] == 4'd0);
      lz[i]    = zero_run;
    end
  end

  // Read mux over pre-write state; unused bits stay zero
  always_comb begin
    rd_word = '0;
    case (reg_sel)
      REG_STATUS: begin
        rd_word[STAT_NOT_EMPTY]             = ~fifo_empty;
        rd_word[STAT_FULL]                  = fifo_full;
        rd_word[STAT_OVF]                   = ovf_q;
        rd_word[STAT_COUNT_LSB +: CNT_W]    = fifo_count;
      end
      REG_KEYDATA:  if (!fifo_empty) rd_word[7:0] = fifo_head;
      REG_LEDS:     rd_word[7:0] = leds_q;
      REG_HEX:      rd_word[HEX_W-1:0] = hex_q;
      REG_HEX_CTRL: rd_word[HC_LZ_BIT:0] = {lz_en_q, blink_mask_q, blank_mask_q};
      default:      rd_word = '0;
    endcase
  end

  // Registered read response; rdata holds until the next read
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= re;
      if (re) rdata_q <= rd_word;
    end
  end

  assign rdata       = rdata_q;
  assign rvalid      = rvalid_q;
  assign leds        = leds_q;
  assign hex_nibbles = hex_q;
  assign key_irq     = ~fifo_empty;
  assign hex_blank   = blank_mask_q[NUM_DIGITS-1:0]
                     | (blink_mask_q[NUM_DIGITS-1:0] & {NUM_DIGITS{phase_q}})
                     | lz;

endmodule
